grey_code_sequencer: RTL and testbench
======================================

// Module: grey_code_sequencer
// PURPOSE
//  Sequences a binary counter through a programmed range and presents each value
//  with its Grey-code equivalent on a valid/ready output stream.
//  Sits between a control master (start/stop, range, direction) and downstream
//  consumers of Grey codes, such as encoder stimulus and cross-domain pointer tests.
//  Runs one-shot or continuous, counts up or down, and wraps modulo 2^WIDTH.
// PARAMETERS
//  WIDTH     4   code width in bits for the counter, first/last bounds and outputs
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      synchronous, active-high reset
//  start       in   1      begin a sequence (accepted in IDLE only)
//  stop        in   1      abort the current sequence
//  cont        in   1      1 = continuous (restart at first_bin), 0 = one-shot
//  up_dn       in   1      1 = count up, 0 = count down
//  first_bin   in   WIDTH  first binary value of the sequence
//  last_bin    in   WIDTH  last binary value of the sequence (inclusive)
//  out_ready   in   1      downstream accepts the current beat
//  out_valid   out  1      binary_out/grey_out hold a valid beat
//  binary_out  out  WIDTH  current binary count
//  grey_out    out  WIDTH  binary_out ^ (binary_out >> 1), registered
//  busy        out  1      high in RUN state
//  done        out  1      one-cycle pulse when a one-shot sequence completes
//  wrap        out  1      one-cycle pulse on modulo wrap or continuous restart
// BEHAVIOUR
//  - Reset: state=IDLE. out_valid, busy, done, wrap = 0. binary_out, grey_out = 0.
//  - FSM IDLE -> RUN -> DONE -> IDLE. Every output is registered.
//  - IDLE: start=1 and stop=0 -> RUN on the next edge.
//      Load binary_out=first_bin and grey_out=gray(first_bin).
//      Capture cont, up_dn and last_bin into internal registers.
//      out_valid rises one cycle after start.
//  - start and stop in the same cycle while in IDLE -> stay in IDLE.
//  - In RUN, start is ignored. Config inputs are ignored after capture.
//  - Handshake: a beat transfers when out_valid && out_ready.
//      While out_valid=1 and out_ready=0, binary_out and grey_out hold stable.
//  - On a transfer in RUN:
//      If binary_out != last, step to binary_out +1 (up) or -1 (down), mod 2^WIDTH.
//        Pulse wrap when stepping 2^WIDTH-1 -> 0 (up) or 0 -> 2^WIDTH-1 (down).
//      If binary_out == last and cont=1, reload first_bin and pulse wrap.
//      If binary_out == last and cont=0, go to DONE and drop out_valid.
//  - The grey_out update is in the same edge as binary_out, so the pair is always consistent.
//  - DONE: done=1 for one cycle, then IDLE. binary_out/grey_out keep the last value.
//  - first==last: a single beat is issued.
//      One-shot: done follows.
//      Continuous: the same code repeats, with a wrap pulse each beat.
//  - stop=1 in RUN -> IDLE on the next edge, and done stays 0.
//      A transfer in that same cycle counts as accepted, but no further beat is issued.
//  - rst mid-sequence: outputs return to reset values on the next edge.
//  - Throughput: one beat per clock while out_ready=1.
// STRUCTURE
//  - grey_pkg holds:
//      state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
//      function bin2grey(WIDTH) returning b ^ (b >> 1).
//  - One sub-module: grey_seq_counter (loadable mod-2^WIDTH up/down counter with wrap flag).
//  - FSM and handshake logic stay in the top level.
// TESTING
//  1. Reset, then first=0, last=15, up, one-shot, out_ready=1.
//     -> grey_out 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000
//     -> done one cycle after the 1000 transfer.
//  2. Down-count first=2, last=14 (4-bit).
//     -> binaries 2,1,0,15,14; wrap pulses on 0->15; grey_out of 14 = 1001.
//  3. out_ready toggled 1,0,0,1.
//     -> grey_out holds 0011 for the two stalled cycles; no beat is lost or duplicated.
//  4. cont=1, first=5, last=6.
//     -> beats 5,6,5,6... with wrap on each 6->5 reload; done never asserts.
//  5. stop asserted on the third beat with out_ready=1.
//     -> IDLE next cycle; out_valid=0, done=0, binary_out holds the value at stop.
//  6. rst pulsed mid-RUN, and start+stop together in IDLE.
//     -> all outputs 0 and state IDLE; the start is ignored.

Source files
------------

// File: rtl/grey_pkg.sv
// Shared state encoding and the binary-to-Grey conversion used by the sequencer.
package grey_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int GREY_MAX_WIDTH = 32;

  // Callers zero-extend into and truncate out of the fixed-width argument.
  function automatic logic [GREY_MAX_WIDTH-1:0] bin2grey(input logic [GREY_MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/grey_code_sequencer_counter.sv
// Loadable modulo-2^WIDTH up/down counter with a registered Grey shadow and wrap flag.
module grey_seq_counter
  import grey_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] grey,
  output logic             wrap_flag
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ZERO     = '0;

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] grey_reg;
  logic [WIDTH-1:0] grey_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_val;
    end else if (step) begin
      count_next = up_dn ? (count_reg + ONE) : (count_reg - ONE);
    end
    // Grey code tracks the next count so both registers update on the same edge.
    grey_next = WIDTH'(bin2grey(GREY_MAX_WIDTH'(count_next)));
  end

  // Flags the step that crosses the modulo boundary; load takes priority.
  assign wrap_flag = step && !load &&
                     (up_dn ? (count_reg == ALL_ONES) : (count_reg == ZERO));

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      grey_reg  <= '0;
    end else begin
      count_reg <= count_next;
      grey_reg  <= grey_next;
    end
  end

  assign count = count_reg;
  assign grey  = grey_reg;

endmodule

// File: rtl/grey_code_sequencer.sv
// Sequences a binary count through a programmed range and streams each value with
// its Grey code on a valid/ready interface; FSM and handshake live here.
module grey_code_sequencer
  import grey_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cont,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] first_bin,
  input  logic [WIDTH-1:0] last_bin,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] binary_out,
  output logic [WIDTH-1:0] grey_out,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_t state_reg;
  state_t state_next;

  logic             cont_reg;
  logic             up_dn_reg;
  logic [WIDTH-1:0] first_reg;
  logic [WIDTH-1:0] last_reg;
  logic             capture;

  logic out_valid_reg, out_valid_next;
  logic busy_reg, busy_next;
  logic done_reg, done_next;
  logic wrap_reg, wrap_next;

  logic             cnt_load;
  logic [WIDTH-1:0] cnt_load_val;
  logic             cnt_step;
  logic [WIDTH-1:0] cnt_count;
  logic [WIDTH-1:0] cnt_grey;
  logic             cnt_wrap;
  logic             xfer;

  assign xfer = out_valid_reg && out_ready;

  grey_seq_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .step     (cnt_step),
    .up_dn    (up_dn_reg),
    .count    (cnt_count),
    .grey     (cnt_grey),
    .wrap_flag(cnt_wrap)
  );

  always_comb begin
    state_next     = state_reg;
    capture        = 1'b0;
    cnt_load       = 1'b0;
    cnt_load_val   = first_reg;
    cnt_step       = 1'b0;
    out_valid_next = 1'b0;
    busy_next      = 1'b0;
    done_next      = 1'b0;
    wrap_next      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start && !stop) begin
          state_next     = S_RUN;
          capture        = 1'b1;
          cnt_load       = 1'b1;
          cnt_load_val   = first_bin;
          out_valid_next = 1'b1;
          busy_next      = 1'b1;
        end
      end

      S_RUN: begin
        out_valid_next = 1'b1;
        busy_next      = 1'b1;
        // A beat accepted alongside stop is consumed, but the count does not advance.
        if (stop) begin
          state_next     = S_IDLE;
          out_valid_next = 1'b0;
          busy_next      = 1'b0;
        end else if (xfer) begin
          if (cnt_count != last_reg) begin
            cnt_step  = 1'b1;
            wrap_next = cnt_wrap;
          end else if (cont_reg) begin
            cnt_load  = 1'b1;
            wrap_next = 1'b1;
          end else begin
            state_next     = S_DONE;
            out_valid_next = 1'b0;
            busy_next      = 1'b0;
            done_next      = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      wrap_reg      <= 1'b0;
      cont_reg      <= 1'b0;
      up_dn_reg     <= 1'b0;
      first_reg     <= '0;
      last_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= out_valid_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      wrap_reg      <= wrap_next;
      if (capture) begin
        cont_reg  <= cont;
        up_dn_reg <= up_dn;
        first_reg <= first_bin;
        last_reg  <= last_bin;
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign binary_out = cnt_count;
  assign grey_out   = cnt_grey;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign wrap       = wrap_reg;

endmodule

// File: tb/tb_grey_code_sequencer.sv
// Directed bench for grey_code_sequencer: a cycle model derived from the behaviour rules,
// a reflected-Grey lookup table, and literal expectations that pin both.
module tb_grey_code_sequencer;

  localparam int W = 4;
  localparam int N = 1 << W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic cont = 1'b0;
  logic up_dn = 1'b1;
  logic [W-1:0] first_bin = '0;
  logic [W-1:0] last_bin = '0;
  logic out_ready = 1'b0;
  logic out_valid;
  logic [W-1:0] binary_out;
  logic [W-1:0] grey_out;
  logic busy;
  logic done;
  logic wrap;

  always #5 clk = ~clk;

  grey_code_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .cont      (cont),
    .up_dn     (up_dn),
    .first_bin (first_bin),
    .last_bin  (last_bin),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .binary_out(binary_out),
    .grey_out  (grey_out),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  // Grey table built by reflection, independent of the xor formula.
  int gray_tab [N];
  initial begin
    gray_tab[0] = 0;
    for (int k = 0; k < W; k++)
      for (int i = 0; i < (1 << k); i++)
        gray_tab[(1 << k) + i] = (1 << k) | gray_tab[(1 << k) - 1 - i];
  end

  // Behavioural model: mode 0 idle, 1 running, 2 finishing.
  int m_mode = 0, m_bin = 0, m_first = 0, m_last = 0;
  bit m_cont = 0, m_up = 0, m_valid = 0, m_busy = 0, m_done = 0, m_wrap = 0;
  int done_cnt = 0, wrap_cnt = 0;
  int beats[$];

  always @(posedge clk) begin
    bit accepted;
    if (rst) begin
      m_mode = 0; m_bin = 0; m_valid = 0; m_busy = 0; m_done = 0; m_wrap = 0;
    end else begin
      accepted = m_valid && out_ready;
      if (accepted) begin
        beats.push_back(m_bin);
        $display("beat bin=%0d grey=%04b", m_bin, 4'(gray_tab[m_bin]));
      end
      m_done = 0;
      m_wrap = 0;
      if (m_mode == 0) begin
        if (start && !stop) begin
          m_mode = 1; m_bin = int'(first_bin); m_first = int'(first_bin);
          m_last = int'(last_bin); m_cont = cont; m_up = up_dn; m_valid = 1;
        end
      end else if (m_mode == 1) begin
        if (stop) begin
          m_mode = 0; m_valid = 0;
        end else if (accepted) begin
          if (m_bin != m_last) begin
            m_wrap = m_up ? (m_bin == N - 1) : (m_bin == 0);
            m_bin  = m_up ? (m_bin + 1) % N : (m_bin + N - 1) % N;
          end else if (m_cont) begin
            m_bin = m_first; m_wrap = 1;
          end else begin
            m_mode = 2; m_valid = 0; m_done = 1;
          end
        end
      end else begin
        m_mode = 0;
      end
      m_busy = (m_mode == 1);
      done_cnt += int'(m_done);
      wrap_cnt += int'(m_wrap);
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance one clock and compare every output against the model.
  task automatic tick();
    @(posedge clk);
    #1;
    check("cycle{valid,busy,done,wrap,bin,grey}",
          32'({out_valid, busy, done, wrap, binary_out, grey_out}),
          32'({m_valid, m_busy, m_done, m_wrap, 4'(m_bin), 4'(gray_tab[m_bin])}));
  endtask

  task automatic start_seq(input int f, input int l, input bit u, input bit c);
    first_bin = W'(f); last_bin = W'(l); up_dn = u; cont = c;
    start = 1'b1; stop = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done_cnt > d0) seen = 1;
    end
    check("wait_done_in_budget", 32'(seen), 32'd1);
  endtask

  logic [3:0] exp_grey1 [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                 4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                 4'b1010, 4'b1011, 4'b1001, 4'b1000};
  int exp_bin2 [5] = '{2, 1, 0, 15, 14};

  initial begin
    int base, w0, d0;

    repeat (3) tick();
    rst = 1'b0;
    check("reset_outputs", 32'({out_valid, busy, done, wrap, binary_out, grey_out}), 32'd0);

    // Full up-count one-shot.
    out_ready = 1'b1;
    base = beats.size();
    start_seq(0, 15, 1'b1, 1'b0);
    wait_done(40);
    check("t1_done_pulse", 32'(done), 32'd1);
    check("t1_beat_count", 32'(beats.size() - base), 32'd16);
    for (int i = 0; i < 16 && base + i < beats.size(); i++)
      check($sformatf("t1_grey[%0d]", i), 32'(gray_tab[beats[base + i]]), 32'(exp_grey1[i]));
    tick();

    // Down-count across zero.
    base = beats.size(); w0 = wrap_cnt;
    start_seq(2, 14, 1'b0, 1'b0);
    wait_done(20);
    check("t2_beat_count", 32'(beats.size() - base), 32'd5);
    for (int i = 0; i < 5 && base + i < beats.size(); i++)
      check($sformatf("t2_bin[%0d]", i), 32'(beats[base + i]), 32'(exp_bin2[i]));
    check("t2_wrap_count", 32'(wrap_cnt - w0), 32'd1);
    check("t2_grey_of_14", 32'(grey_out), 32'b1001);
    tick();

    // Back-pressure: ready 1,1 then 0,0 while 2 is presented, then 1.
    base = beats.size();
    start_seq(0, 4, 1'b1, 1'b0);
    tick();
    tick();
    out_ready = 1'b0;
    tick();
    check("t3_stall1_grey", 32'(grey_out), 32'b0011);
    tick();
    check("t3_stall2_grey", 32'(grey_out), 32'b0011);
    out_ready = 1'b1;
    wait_done(20);
    check("t3_beat_count", 32'(beats.size() - base), 32'd5);
    for (int i = 0; i < 5 && base + i < beats.size(); i++)
      check($sformatf("t3_bin[%0d]", i), 32'(beats[base + i]), 32'(i));
    tick();

    // Continuous 5..6, then stop.
    base = beats.size(); w0 = wrap_cnt; d0 = done_cnt;
    start_seq(5, 6, 1'b1, 1'b1);
    repeat (12) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    check("t4_beat_count", 32'(beats.size() - base), 32'd13);
    for (int i = 0; i < 13 && base + i < beats.size(); i++)
      check($sformatf("t4_bin[%0d]", i), 32'(beats[base + i]), (i % 2) ? 32'd6 : 32'd5);
    check("t4_wrap_count", 32'(wrap_cnt - w0), 32'd6);
    check("t4_no_done", 32'(done_cnt - d0), 32'd0);
    check("t4_valid_after_stop", 32'(out_valid), 32'd0);

    // Stop on the third beat.
    d0 = done_cnt;
    start_seq(8, 15, 1'b1, 1'b0);
    tick();
    tick();
    check("t5_third_beat", 32'(binary_out), 32'd10);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t5_state_after_stop", 32'({out_valid, busy, done}), 32'd0);
    check("t5_bin_held", 32'(binary_out), 32'd10);
    check("t5_grey_held", 32'(grey_out), 32'b1111);
    repeat (2) tick();
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);

    // Reset mid-run, then start+stop together in idle.
    start_seq(3, 12, 1'b1, 1'b0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_reset_outputs", 32'({out_valid, busy, done, wrap, binary_out, grey_out}), 32'd0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("t6_start_stop_ignored", 32'({out_valid, busy}), 32'd0);
    repeat (2) tick();
    check("t6_still_idle", 32'({out_valid, busy, binary_out}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
